nbcac_decoder_pipe: RTL and testbench
=====================================

// Module: nbcac_decoder_pipe
// PURPOSE
//  Parametrised, pipelined FNS-weighted CAC codeword decoder with valid/ready flow control.
//  Decodes a CODE_W-wire crosstalk-avoidance codeword into DATA_W data bits.
//  Flags forbidden-pattern and range violations, and counts errored words.
//  Sits at the receive end of a CAC-coded bus, in place of fixed-width single-register decoders.
// PARAMETERS
//  CODE_W    29  codeword width; codein indexed [CODE_W:1]; >=3
//  DATA_W    20  decoded data width; 1..CODE_W
//  PIPE       3  pipeline stages (= latency in cycles); 1..CODE_W
//  ERRCNT_W  16  width of the saturating error counter
// PORTS
//  clock      in   1         rising-edge clock
//  rst_n      in   1         async active-low reset
//  in_valid   in   1         codein is valid this cycle
//  in_ready   out  1         block accepts codein this cycle
//  codein     in   CODE_W    codeword, bits [CODE_W:1]
//  out_valid  out  1         dataout/out_err are valid
//  out_ready  in   1         downstream accepts the output word
//  dataout    out  DATA_W    decoded word
//  out_err    out  1         error flag for the word on dataout
//  clr_cnt    in   1         synchronous clear of err_count
//  err_count  out  ERRCNT_W  count of errored words delivered
// BEHAVIOUR
//  Decode arithmetic:
//  - Weight W_i = Fib(i+1), with Fib(1)=Fib(2)=1, so W_1=1, W_2=2, W_3=3, W_4=5, ...
//  - S = sum over i=1..CODE_W of codein[i]*W_i. Accumulate at CODE_W bits; S < 2^CODE_W always.
//  - dataout = S mod 2^DATA_W.
//  Error flag: out_err = range_err | pat_err.
//  - range_err: S >= 2^DATA_W.
//  - pat_err: any i in 1..CODE_W-2 with (codein[i],codein[i+1],codein[i+2]) = 010 or 101.
//  Pipeline:
//  - Bits are split into PIPE contiguous chunks of ceil(CODE_W/PIPE) bits, bit 1 upward.
//  - Stage k adds chunk k's weighted bits and pattern check into a partial sum and partial
//    error, carried forward with the raw codeword (boundary triples need the neighbouring bits).
//  - Results register at the last stage.
//  Handshake:
//  - Transfer on the input when in_valid & in_ready.
//  - Transfer on the output when out_valid & out_ready.
//  - Global stall = out_valid & ~out_ready. When stalled, every stage holds.
//  - in_ready = ~stall (combinational from out_ready).
//  - Otherwise all stages advance each cycle; bubbles (valid=0) propagate.
//  - Latency: accepted word appears on out_valid exactly PIPE cycles later if never stalled.
//  - Throughput: 1 word/cycle. Order preserved. No word lost or duplicated under any
//    out_ready pattern.
//  - dataout/out_err are stable while out_valid & ~out_ready. Their values are don't-care
//    when out_valid=0.
//  Error counter (err_count):
//  - +1 on each output transfer with out_err=1.
//  - Saturates at 2^ERRCNT_W-1.
//  - clr_cnt=1 sets it to 0 next cycle, and wins over a simultaneous increment.
//  Reset (rst_n low, any time including mid-stream):
//  - All stage valids=0, out_valid=0, dataout=0, out_err=0, err_count=0.
//  - In-flight words are discarded.
//  - in_ready=1 from the first cycle after release.
// TESTING (CODE_W=29, DATA_W=20, PIPE=3 unless stated)
//  1. codein=0 -> dataout=0, out_err=0, 3 cycles after accept.
//  2. codein=29'h1 -> 1; 29'h3 -> 3; 29'h7 -> 6; 29'hF -> 11; all with out_err=0.
//  3. Forbidden patterns:
//     - 29'h2 (010 on bits 1..3) -> dataout=2, out_err=1.
//     - 29'h5 (101) -> dataout=4, out_err=1.
//  4. codein all ones -> S=2178307, dataout=81155, out_err=1 (range error only).
//  5. Stream 10 words back-to-back with out_ready low for cycles 4..8:
//     - in_ready low exactly while stalled.
//     - All 10 outputs delivered in order, values held stable during the stall.
//  6. Counter and reset:
//     - ERRCNT_W=2: 5 errored words -> err_count 1,2,3,3,3.
//     - clr_cnt coincident with an errored transfer -> 0.
//     - rst_n pulsed with 2 words in flight -> out_valid=0, and neither word ever appears.

Source files
------------

// File: rtl/nbcac_decoder_pipe_if.sv
// Bus bundle for the pipelined FNS-weighted CAC decoder: input handshake with
// the codeword, output handshake with the decoded word and error flag, plus
// the error-counter clear and readout.
interface nbcac_decoder_pipe_if #(
   parameter int CODE_W   = 29,
   parameter int DATA_W   = 20,
   parameter int ERRCNT_W = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [CODE_W:1]     codein;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   dataout;
   logic                out_err;
   logic                clr_cnt;
   logic [ERRCNT_W-1:0] err_count;

   // Upstream/downstream side that feeds codewords and consumes results
   modport master (
      output in_valid, codein, out_ready, clr_cnt,
      input  in_ready, out_valid, dataout, out_err, err_count
   );

   // Decoder side
   modport slave (
      input  in_valid, codein, out_ready, clr_cnt,
      output in_ready, out_valid, dataout, out_err, err_count
   );
endinterface

// File: rtl/nbcac_decoder_pipe.sv
// Pipelined Fibonacci-weighted CAC decoder. The codeword is split into PIPE
// contiguous chunks starting at bit 1; each stage adds its chunk's weighted
// bits and forbidden-pattern hits into a running partial sum/error while the
// raw codeword rides along so boundary triples can see their neighbours.
// One global stall (output valid but not taken) freezes every stage.
module nbcac_decoder_pipe #(
   parameter int CODE_W   = 29,
   parameter int DATA_W   = 20,
   parameter int PIPE     = 3,
   parameter int ERRCNT_W = 16
) (
   input logic                 clock,
   input logic                 rst_n,
   nbcac_decoder_pipe_if.slave bus
);

   localparam int CHUNK = (CODE_W + PIPE - 1) / PIPE;
   localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

   // Weight of bit i is Fib(i+1): 1, 2, 3, 5, 8, ...
   function automatic logic [CODE_W-1:0] fib_weight(input int i);
      logic [CODE_W:0] f_prev;
      logic [CODE_W:0] f_cur;
      logic [CODE_W:0] f_next;
      f_prev = {{CODE_W{1'b0}}, 1'b1};
      f_cur  = {{CODE_W{1'b0}}, 1'b1};
      for (int j = 1; j < i; j++) begin
         f_next = f_prev + f_cur;
         f_prev = f_cur;
         f_cur  = f_next;
      end
      return f_cur[CODE_W-1:0];
   endfunction

   logic              valid_q [PIPE];
   logic [CODE_W:1]   code_q  [PIPE];
   logic [CODE_W-1:0] sum_q   [PIPE];
   logic              err_q   [PIPE];

   logic              valid_d [PIPE];
   logic [CODE_W:1]   code_d  [PIPE];
   logic [CODE_W-1:0] sum_in  [PIPE];
   logic              err_in  [PIPE];
   logic [CODE_W-1:0] sum_d   [PIPE];
   logic              err_d   [PIPE];

   logic [ERRCNT_W-1:0] cnt_q;
   logic                stall;
   logic                out_xfer;

   assign stall    = bus.out_valid & ~bus.out_ready;
   assign out_xfer = bus.out_valid & bus.out_ready;

   assign bus.in_ready  = ~stall;
   assign bus.out_valid = valid_q[PIPE-1];
   assign bus.dataout   = sum_q[PIPE-1][DATA_W-1:0];
   assign bus.out_err   = err_q[PIPE-1];
   assign bus.err_count = cnt_q;

   // Per-stage partial decode: chunk k adds its weights and pattern hits
   always_comb begin
      valid_d[0] = bus.in_valid;
      code_d[0]  = bus.codein;
      sum_in[0]  = '0;
      err_in[0]  = 1'b0;
      for (int k = 1; k < PIPE; k++) begin
         valid_d[k] = valid_q[k-1];
         code_d[k]  = code_q[k-1];
         sum_in[k]  = sum_q[k-1];
         err_in[k]  = err_q[k-1];
      end
      for (int k = 0; k < PIPE; k++) begin
         sum_d[k] = sum_in[k];
         err_d[k] = err_in[k];
         for (int i = 1; i <= CODE_W; i++) begin
            if (i >= k * CHUNK + 1 && i <= (k + 1) * CHUNK && code_d[k][i]) begin
               sum_d[k] = sum_d[k] + fib_weight(i);
            end
         end
         // A triple is owned by the stage holding its lowest bit
         for (int i = 1; i <= CODE_W - 2; i++) begin
            if (i >= k * CHUNK + 1 && i <= (k + 1) * CHUNK &&
                (code_d[k][i +: 3] == 3'b010 || code_d[k][i +: 3] == 3'b101)) begin
               err_d[k] = 1'b1;
            end
         end
      end
      // Range check folded into the last stage once the full sum is known
      if ((sum_d[PIPE-1] >> DATA_W) != '0) begin
         err_d[PIPE-1] = 1'b1;
      end
   end

   // Stage registers: advance together unless the output is stalled
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE; k++) begin
            valid_q[k] <= 1'b0;
            code_q[k]  <= '0;
            sum_q[k]   <= '0;
            err_q[k]   <= 1'b0;
         end
      end else if (!stall) begin
         for (int k = 0; k < PIPE; k++) begin
            valid_q[k] <= valid_d[k];
            code_q[k]  <= code_d[k];
            sum_q[k]   <= sum_d[k];
            err_q[k]   <= err_d[k];
         end
      end
   end

   // Saturating count of errored words delivered; clear has priority
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (bus.clr_cnt) begin
         cnt_q <= '0;
      end else if (out_xfer && bus.out_err && cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_nbcac_decoder_pipe.sv
// Self-checking bench for nbcac_decoder_pipe: directed cases, a stalled
// stream, counter saturation/clear on a narrow-counter instance, mid-stream
// reset, and a randomized run checked against a behavioural decode model.
module tb_nbcac_decoder_pipe;

   localparam int CW = 29;
   localparam int DW = 20;
   localparam int NP = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   nbcac_decoder_pipe_if #(.CODE_W(CW), .DATA_W(DW), .ERRCNT_W(16)) bus ();
   nbcac_decoder_pipe_if #(.CODE_W(CW), .DATA_W(DW), .ERRCNT_W(2))  bus2 ();

   nbcac_decoder_pipe #(.CODE_W(CW), .DATA_W(DW), .PIPE(NP), .ERRCNT_W(16)) dut (
      .clock (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   nbcac_decoder_pipe #(.CODE_W(CW), .DATA_W(DW), .PIPE(NP), .ERRCNT_W(2)) dut2 (
      .clock (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   int n_checks  = 0;
   int n_pass    = 0;
   int model_cnt = 0;
   int n_seen    = 0;
   bit drv_done  = 1'b0;
   logic [20:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference decode: {err, data} from plain Fibonacci arithmetic
   function automatic logic [20:0] ref_word(input logic [CW:1] c);
      longint s  = 0;
      longint fa = 1;
      longint fb = 1;
      longint t;
      logic   e  = 1'b0;
      logic [DW-1:0] d;
      for (int i = 1; i <= CW; i++) begin
         if (c[i]) s += fb;
         t  = fa + fb;
         fa = fb;
         fb = t;
      end
      for (int i = 1; i <= CW - 2; i++)
         if (c[i] != c[i+1] && c[i+1] != c[i+2]) e = 1'b1;
      if (s >= (longint'(1) << DW)) e = 1'b1;
      d = DW'(s % (longint'(1) << DW));
      return {e, d};
   endfunction

   function automatic logic [CW:1] gen_code();
      logic [CW:1] c = '0;
      logic b;
      int   i, run;
      case ($urandom_range(0, 3))
         0: c = CW'($urandom);
         1: c = CW'($urandom_range(0, (1 << DW) - 1));
         2: begin
            b = 1'($urandom_range(0, 1));
            i = 1;
            while (i <= CW) begin
               run = $urandom_range(2, 5);
               for (int j = 0; j < run && i <= CW; j++) begin
                  c[i] = b;
                  i++;
               end
               b = ~b;
            end
            if ($urandom_range(0, 1) == 1) c[CW:18] = '0;
         end
         default: c = ($urandom_range(0, 1) == 1) ? '1 : '0;
      endcase
      return c;
   endfunction

   // Present one word; called and returns at posedge+1
   task automatic send_word(input logic [CW:1] c, input logic [20:0] exp);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.codein   = c;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'(1));
      else exp_q.push_back(exp);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic send2(input logic [CW:1] c);
      bus2.in_valid = 1'b1;
      bus2.codein   = c;
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
   endtask

   // Output monitor: every valid word must match the scoreboard head
   always @(negedge clk) begin
      logic [20:0] w;
      if (rst_n) begin
         check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
         if (bus.out_valid) begin
            n_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'(exp_q.size()), 64'(1));
            end else begin
               w = exp_q[0];
               check(bus.out_ready ? "data" : "held_data", 64'(bus.dataout), 64'(w[19:0]));
               check(bus.out_ready ? "err" : "held_err", 64'(bus.out_err), 64'(w[20]));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  if (w[20] && model_cnt < 65535) model_cnt++;
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n_low;
      logic [CW:1] c;

      bus.in_valid  = 1'b0;
      bus.codein    = '0;
      bus.out_ready = 1'b1;
      bus.clr_cnt   = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.codein    = '0;
      bus2.out_ready = 1'b1;
      bus2.clr_cnt   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_dataout",   64'(bus.dataout),   64'(0));
      check("rst_out_err",   64'(bus.out_err),   64'(0));
      check("rst_err_count", 64'(bus.err_count), 64'(0));
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Zero codeword and latency of exactly PIPE cycles
      send_word('0, 21'h0);
      @(negedge clk);
      check("lat_cycle1", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      check("lat_cycle2", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      check("lat_cycle3", 64'(bus.out_valid), 64'(1));
      drain();

      // Directed values, back to back
      send_word(29'h1, {1'b0, 20'd1});
      send_word(29'h3, {1'b0, 20'd3});
      send_word(29'h7, {1'b0, 20'd6});
      send_word(29'hF, {1'b0, 20'd11});
      send_word(29'h2, {1'b1, 20'd2});
      send_word(29'h5, {1'b1, 20'd4});
      send_word('1,    {1'b1, 20'd81155});
      drain();
      check("err_count_directed", 64'(bus.err_count), 64'(model_cnt));

      // 10-word stream with out_ready low in cycles 4..8
      n_low = 0;
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               c = CW'(k * 1237 + 5);
               send_word(c, ref_word(c));
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
         begin
            repeat (20) begin
               @(negedge clk);
               if (!bus.in_ready) n_low++;
            end
         end
      join
      check("stall_cycles", 64'(n_low), 64'(5));
      drain();

      // Saturating counter on the 2-bit instance
      check("cnt2_start", 64'(bus2.err_count), 64'(0));
      for (int j = 0; j < 5; j++) begin
         send2(29'h2);
         repeat (3) @(posedge clk);
         @(negedge clk);
         check($sformatf("cnt2_step%0d", j), 64'(bus2.err_count), 64'((j + 1 < 3) ? j + 1 : 3));
         @(posedge clk);
         #1;
      end
      // Clear coincident with an errored transfer
      send2(29'h5);
      repeat (2) @(posedge clk);
      #1 bus2.clr_cnt = 1'b1;
      @(negedge clk);
      check("clr_coincide_valid", 64'(bus2.out_valid), 64'(1));
      check("clr_coincide_err",   64'(bus2.out_err),   64'(1));
      @(posedge clk);
      #1 bus2.clr_cnt = 1'b0;
      @(negedge clk);
      check("clr_wins", 64'(bus2.err_count), 64'(0));
      @(posedge clk);
      #1;

      // Randomized run against the model
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               if ($urandom_range(0, 3) == 0)
                  repeat ($urandom_range(1, 3)) begin
                     @(posedge clk);
                     #1;
                  end
               c = gen_code();
               send_word(c, ref_word(c));
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 9) < 7);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("err_count_random", 64'(bus.err_count), 64'(model_cnt));

      // Mid-stream reset with two words in flight
      send_word(29'h3, {1'b0, 20'd3});
      send_word(29'h7, {1'b0, 20'd6});
      #2 rst_n = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready",  64'(bus.in_ready),  64'(1));
      check("midrst_dataout",   64'(bus.dataout),   64'(0));
      check("midrst_out_err",   64'(bus.out_err),   64'(0));
      check("midrst_err_count", 64'(bus.err_count), 64'(0));
      n_seen = 0;
      repeat (10) @(negedge clk);
      check("ghost_words", 64'(n_seen), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
